// File: rtl/ov7670_stream_rx.sv
// ov7670_stream_rx
// Receiver for an OV7670-style parallel camera. Generates the sensor master
// clock, brings PCLK/VSYNC/HREF/DATA into the system clock domain, assembles
// 1- or 2-byte pixels, optionally decimates in H and V, and emits each kept
// pixel together with its frame-buffer column/row address.
//
// Optional feature: define OV7670_RX_STATS_EN to add o_frame_count.
//
// Ports:
//   i_clk, i_n_reset        system clock, asynchronous active-low reset
//   i_start_capture         level: capture every frame while high
//   i_next_frame            pulse: arm capture of exactly one frame
//   i_PCLK, i_VS, i_HS,     sensor pins (asynchronous to i_clk)
//   i_DATA
//   o_XCLK                  sensor master clock
//   o_pixel_data            assembled pixel, first byte in the MSBs
//   o_h_addr, o_v_addr      output column / row of o_pixel_data
//   o_valid                 one-cycle strobe qualifying pixel + addresses
//   o_frame_done            one-cycle strobe at the end of a captured frame
//   o_error                 sticky frame-geometry error, cleared at frame start
//   o_frame_count           (OV7670_RX_STATS_EN only) captured frame counter
//
// Output handshake: o_valid is a pure strobe with no ready/backpressure; the
// consumer must accept pixel and addresses in the cycle o_valid is high.
module ov7670_stream_rx #(
  parameter int DATA_WIDTH      = 8,
  parameter int H_WIDTH         = 640,
  parameter int V_WIDTH         = 480,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PXL_WIDTH       = DATA_WIDTH * BYTES_PER_PIXEL,
  parameter int DECIM           = 1,
  parameter int CLK_FREQ        = 100_000_000,
  parameter int XCLK_FREQ       = 24_000_000
) (
  input  logic                               i_clk,
  input  logic                               i_n_reset,
  input  logic                               i_start_capture,
  input  logic                               i_next_frame,
  input  logic                               i_PCLK,
  input  logic                               i_VS,
  input  logic                               i_HS,
  input  logic [DATA_WIDTH-1:0]              i_DATA,
  output logic                               o_XCLK,
  output logic [PXL_WIDTH-1:0]               o_pixel_data,
  output logic [$clog2(H_WIDTH/DECIM):0]     o_h_addr,
  output logic [$clog2(V_WIDTH/DECIM):0]     o_v_addr,
  output logic                               o_valid,
  output logic                               o_frame_done,
`ifdef OV7670_RX_STATS_EN
  output logic [15:0]                        o_frame_count,
`endif
  output logic                               o_error
);

  localparam int DIV_RAW = CLK_FREQ / (2 * XCLK_FREQ);
  localparam int DIV     = (DIV_RAW > 1) ? DIV_RAW : 1;
  localparam int DIV_W   = $clog2(DIV + 1);
  localparam int HA_W    = $clog2(H_WIDTH / DECIM) + 1;
  localparam int VA_W    = $clog2(V_WIDTH / DECIM) + 1;
  // One spare bit so over-long lines / frames remain distinguishable.
  localparam int HC_W    = $clog2(H_WIDTH + 1) + 1;
  localparam int LC_W    = $clog2(V_WIDTH + 1) + 1;
  localparam int PH_W    = 2;
  localparam int DSH     = $clog2(DECIM);

  localparam logic [HC_W-1:0] H_MAX  = HC_W'(H_WIDTH);
  localparam logic [LC_W-1:0] V_MAX  = LC_W'(V_WIDTH);
  localparam logic [HC_W-1:0] H_MASK = HC_W'(DECIM - 1);
  localparam logic [LC_W-1:0] L_MASK = LC_W'(DECIM - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BYTES_PER_PIXEL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_ACTIVE, ST_DONE} state_e;

  // ---------------------------------------------------------------- XCLK
  logic [DIV_W-1:0] xdiv_q;
  logic             xclk_q;

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      xdiv_q <= '0;
      xclk_q <= 1'b0;
    end else if (xdiv_q == DIV_W'(DIV - 1)) begin
      xdiv_q <= '0;
      xclk_q <= ~xclk_q;
    end else begin
      xdiv_q <= xdiv_q + 1'b1;
    end
  end

  assign o_XCLK = xclk_q;

  // -------------------------------------------------------- synchronisers
  // Bit 0 = stage 1, bit 1 = stage 2, bit 2 = stage 3 (edge-detect history).
  logic [2:0]            pclk_s_q, vs_s_q, hs_s_q;
  logic [DATA_WIDTH-1:0] data_s1_q, data_s2_q;

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      pclk_s_q  <= '0;
      vs_s_q    <= '0;
      hs_s_q    <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      pclk_s_q  <= {pclk_s_q[1:0], i_PCLK};
      vs_s_q    <= {vs_s_q[1:0], i_VS};
      hs_s_q    <= {hs_s_q[1:0], i_HS};
      data_s1_q <= i_DATA;
      data_s2_q <= data_s1_q;
    end
  end

  logic pclk_rise, hs_fall, vs_fall, vs_rise, hs_s2;
  assign pclk_rise = pclk_s_q[1] & ~pclk_s_q[2];
  assign hs_s2     = hs_s_q[1];
  assign hs_fall   = ~hs_s_q[1] & hs_s_q[2];
  assign vs_fall   = ~vs_s_q[1] & vs_s_q[2];
  assign vs_rise   = vs_s_q[1] & ~vs_s_q[2];

  // ------------------------------------------------------------------ FSM
  state_e state_q;
  logic   frame_done_q;
  logic   next_pend_q;

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q      <= ST_IDLE;
      frame_done_q <= 1'b0;
      next_pend_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start_capture || i_next_frame) state_q <= ST_ARM;
        end
        // Only a VS falling edge starts a frame, so a frame already running
        // when we arm is skipped rather than joined midway.
        ST_ARM: begin
          if (vs_fall) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (i_next_frame) next_pend_q <= 1'b1;
          if (vs_rise) state_q <= ST_DONE;
        end
        ST_DONE: begin
          frame_done_q <= 1'b1;
          next_pend_q  <= 1'b0;
          if (i_start_capture || next_pend_q || i_next_frame) state_q <= ST_ARM;
          else                                                state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_frame_done = frame_done_q;

  // ------------------------------------------------------------- datapath
  logic [HC_W-1:0]      hc_q, hc_d;
  logic [LC_W-1:0]      lc_q, lc_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic                 line_q, line_d;   // current line has received a byte
  logic                 err_q, err_d;
  logic [PXL_WIDTH-1:0] sr_q, sr_d;
  logic                 emit;
  logic                 active;
  logic                 byte_evt;

  always_comb begin
    hc_d     = hc_q;
    lc_d     = lc_q;
    phase_d  = phase_q;
    line_d   = line_q;
    err_d    = err_q;
    sr_d     = sr_q;
    emit     = 1'b0;
    active   = (state_q == ST_ACTIVE);
    byte_evt = active && pclk_rise && hs_s2;

    if (state_q == ST_ARM && vs_fall) begin
      hc_d    = '0;
      lc_d    = '0;
      phase_d = '0;
      line_d  = 1'b0;
      err_d   = 1'b0;
    end

    if (byte_evt) begin
      line_d = 1'b1;
      sr_d   = PXL_WIDTH'({sr_q, data_s2_q});
      if (phase_q == PH_LAST) begin
        phase_d = '0;
        emit    = (hc_q < H_MAX) && ((hc_q & H_MASK) == '0) && ((lc_q & L_MASK) == '0);
        if (hc_q != '1) hc_d = hc_q + 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end

    if (!hs_s2) phase_d = '0;

    // Line close: checks use the pre-clear phase and column count.
    if (active && hs_fall && line_q) begin
      if (phase_q != '0 || hc_q != H_MAX) err_d = 1'b1;
      hc_d   = '0;
      line_d = 1'b0;
      if (lc_q != '1) lc_d = lc_q + 1'b1;
    end

    // Frame close sees any byte/line update from the same cycle first.
    if (active && vs_rise && (lc_d != V_MAX || hs_s2)) err_d = 1'b1;
  end

  logic                 valid_q;
  logic [PXL_WIDTH-1:0] pix_q;
  logic [HA_W-1:0]      h_addr_q;
  logic [VA_W-1:0]      v_addr_q;

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      hc_q     <= '0;
      lc_q     <= '0;
      phase_q  <= '0;
      line_q   <= 1'b0;
      err_q    <= 1'b0;
      sr_q     <= '0;
      valid_q  <= 1'b0;
      pix_q    <= '0;
      h_addr_q <= '0;
      v_addr_q <= '0;
    end else begin
      hc_q    <= hc_d;
      lc_q    <= lc_d;
      phase_q <= phase_d;
      line_q  <= line_d;
      err_q   <= err_d;
      sr_q    <= sr_d;
      valid_q <= emit;
      if (emit) begin
        pix_q    <= sr_d;
        h_addr_q <= HA_W'(hc_q >> DSH);
        v_addr_q <= VA_W'(lc_q >> DSH);
      end
    end
  end

  assign o_valid      = valid_q;
  assign o_pixel_data = pix_q;
  assign o_h_addr     = h_addr_q;
  assign o_v_addr     = v_addr_q;
  assign o_error      = err_q;

`ifdef OV7670_RX_STATS_EN
  logic [15:0] frame_cnt_q;

  // Counts in step with the o_frame_done strobe; wraps naturally.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset)               frame_cnt_q <= '0;
    else if (state_q == ST_DONE)  frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign o_frame_count = frame_cnt_q;
`endif

endmodule
